// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_e : sequencer FSM encoding (SYNC -> HOLD -> RELEASE -> RUN)
//   cnt_w       : width of a counter that counts 0..n-1, never less than 1 bit
package reset_seq_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Asynchronous-assert / synchronous-release reset chain.
// Ports:
//   clk      in  system clock
//   rst_n    in  raw board reset, active-low, unsynchronised
//   sync_rst out active-high reset, asserts with rst_n, clears STAGES edges
//                after the first edge that samples rst_n high
module reset_sync #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst
);

  logic [STAGES-1:0] chain;

  // Zeros shift in from the LSB once rst_n is high; the MSB is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset generator: one board reset in, NUM_CH staggered active-high
// resets out. Assertion is immediate and asynchronous; release goes through
// a synchroniser, a MIN_HOLD cycle hold, then one channel every GAP cycles
// starting with ch0. A synchronous soft_rst re-runs the hold and release.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (any edge/level)
//   soft_rst  in   synchronous soft-reset request, level, active-high
//   rst_out   out  [NUM_CH] per-channel reset, active-high
//   seq_busy  out  high while any rst_out bit is asserted
//   seq_done  out  one-cycle pulse when the last channel releases
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGES   = 4,
  parameter int NUM_CH   = 3,
  parameter int MIN_HOLD = 16,
  parameter int GAP      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst,
  output logic [NUM_CH-1:0] rst_out,
  output logic              seq_busy,
  output logic              seq_done
);

  localparam int HW = cnt_w(MIN_HOLD);
  localparam int GW = cnt_w(GAP);
  localparam int CW = cnt_w(NUM_CH);

  localparam logic [HW-1:0]     HOLD_LAST = HW'(MIN_HOLD - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP - 1);
  localparam logic [CW-1:0]     CH_LAST   = CW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

  // Parameter range checks at elaboration.
  if (STAGES < 2) begin : g_bad_stages
    $error("reset_sequencer: STAGES must be >= 2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("reset_sequencer: NUM_CH must be in 1..16");
  end
  if (MIN_HOLD < 1) begin : g_bad_min_hold
    $error("reset_sequencer: MIN_HOLD must be >= 1");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("reset_sequencer: GAP must be >= 1");
  end

  logic sync_rst;

  reset_sync #(.STAGES(STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_rst (sync_rst)
  );

  seq_state_e        state, state_d;
  logic [HW-1:0]     hold_cnt, hold_cnt_d;
  logic [GW-1:0]     gap_cnt, gap_cnt_d;
  logic [CW-1:0]     ch_idx, ch_idx_d;
  logic [CW-1:0]     ch_nx;
  logic [NUM_CH-1:0] rst_out_d;
  logic              seq_done_d;

  assign ch_nx = ch_idx + 1'b1;

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    gap_cnt_d  = gap_cnt;
    ch_idx_d   = ch_idx;
    rst_out_d  = rst_out;
    seq_done_d = 1'b0;

    case (state)
      SYNC: begin
        if (!sync_rst) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        // soft_rst outranks any release or done pulse due this cycle.
        if (soft_rst) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
          ch_idx_d   = '0;
          rst_out_d  = '1;
        end else begin
          case (state)
            HOLD: begin
              if (hold_cnt == HOLD_LAST) begin
                // ch0 releases on the same edge that leaves HOLD.
                rst_out_d = rst_out & ~CH_ONE;
                ch_idx_d  = '0;
                gap_cnt_d = '0;
                if (NUM_CH == 1) begin
                  seq_done_d = 1'b1;
                  state_d    = RUN;
                end else begin
                  state_d = RELEASE;
                end
              end else begin
                hold_cnt_d = hold_cnt + 1'b1;
              end
            end
            RELEASE: begin
              if (gap_cnt == GAP_LAST) begin
                gap_cnt_d = '0;
                ch_idx_d  = ch_nx;
                rst_out_d = rst_out & ~(CH_ONE << ch_nx);
                if (ch_nx == CH_LAST) begin
                  seq_done_d = 1'b1;
                  state_d    = RUN;
                end
              end else begin
                gap_cnt_d = gap_cnt + 1'b1;
              end
            end
            default: begin
              rst_out_d = '0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SYNC;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      ch_idx   <= '0;
      rst_out  <= '1;
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_cnt_d;
      gap_cnt  <= gap_cnt_d;
      ch_idx   <= ch_idx_d;
      rst_out  <= rst_out_d;
      seq_busy <= |rst_out_d;
      seq_done <= seq_done_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
module tb_reset_sequencer;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, soft_rst;
  logic [2:0] rst_out;
  logic       seq_busy, seq_done;

  logic       rst_n2, soft_rst2;
  logic [0:0] rst_out2;
  logic       seq_busy2, seq_done2;

  reset_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_rst (soft_rst),
    .rst_out  (rst_out),
    .seq_busy (seq_busy),
    .seq_done (seq_done)
  );

  reset_sequencer #(.STAGES(2), .NUM_CH(1), .MIN_HOLD(1), .GAP(1)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n2),
    .soft_rst (soft_rst2),
    .rst_out  (rst_out2),
    .seq_busy (seq_busy2),
    .seq_done (seq_done2)
  );

  // Scoreboard: {rst_out, seq_busy, seq_done}
  int         tests = 0;
  int         fails = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Expected default-parameter outputs k edges after the reference edge,
  // with ch0 releasing after edge t0 and GAP = 8.
  function automatic logic [4:0] exp_at(input int k, input int t0);
    logic [2:0] b;
    for (int i = 0; i < 3; i++) b[i] = (k < t0 + i * 8);
    return {b, (k < t0 + 16), (k == t0 + 16)};
  endfunction

  // Called at a negedge; edge 0 is the next posedge. soft_rst is held for
  // the first nsoft edges.
  task automatic run_seq(input string tag, input int t0, input int n, input int nsoft);
    for (int k = 0; k < n; k++) begin
      soft_rst = (k < nsoft);
      exp_q.push_back(exp_at(k, t0));
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, k), {rst_out, seq_busy, seq_done}, exp_q.pop_front());
      @(negedge clk);
    end
    soft_rst = 1'b0;
  endtask

  // Channel ordering: cleared bits must form a contiguous low block.
  logic [2:0] inv;
  always @(negedge clk) begin
    inv = ~rst_out;
    check("order", {4'b0, ((inv & (inv + 3'd1)) == 3'd0)}, 5'b00001);
  end

  initial begin
    rst_n     = 1'b0;
    soft_rst  = 1'b0;
    rst_n2    = 1'b0;
    soft_rst2 = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state of both instances
    exp_q.push_back(5'b11110);
    check("reset", {rst_out, seq_busy, seq_done}, exp_q.pop_front());
    exp_q.push_back(5'b00110);
    check("reset2", {2'b00, rst_out2, seq_busy2, seq_done2}, exp_q.pop_front());

    // 1: power-on release
    rst_n = 1'b1;
    run_seq("s1", 20, 45, 0);

    // 2: short rst_n glitch mid-cycle while in RUN
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    exp_q.push_back(5'b11110);
    check("s2_async", {rst_out, seq_busy, seq_done}, exp_q.pop_front());
    run_seq("s2", 20, 45, 0);

    // 3: one-cycle soft reset from RUN, no synchroniser delay
    run_seq("s3", 16, 40, 1);

    // 4: soft reset on the edge where ch1 would release
    run_seq("s4a", 16, 24, 1);
    run_seq("s4b", 16, 40, 1);

    // 5: soft reset held 40 cycles
    run_seq("s5", 55, 80, 40);

    // 6: minimal configuration, single channel
    rst_n2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({2'b00, (k < 3), (k < 3), (k == 3)});
      @(posedge clk);
      #1;
      check($sformatf("s6[%0d]", k), {2'b00, rst_out2, seq_busy2, seq_done2}, exp_q.pop_front());
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
